uart_rx_axis: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_axis.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_axis.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the board UART receive path.
//   - uart_state_e  : 3-bit receiver state encoding.
//   - UART_BAUD_DIV : default clocks-per-bit for 125 MHz / 460800 baud.
// Optional build macro used by the receiver: UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_CLK_HZ   = 125_000_000;
    localparam int unsigned UART_BAUD     = 460_800;
    localparam int unsigned UART_BAUD_DIV = UART_CLK_HZ / UART_BAUD;  // 271

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// SYNC_STAGES-deep flip-flop synchronizer for an asynchronous level input.
// Flops reset to 1 so an idle-high line never looks like activity after reset.
// Ports:
//   clk     : destination clock
//   rst     : synchronous reset, active-high (presets the chain to 1)
//   async_i : asynchronous input
//   sync_o  : synchronized output
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_axis.sv
// -----------------------------------------------------------------------------
// uart_rx_axis
// UART receiver (8N1 by default) presenting received words as an AXI-stream
// source through a one-entry output register.
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between the
// data bits and the stop bit, plus the parity_error output.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   rxd             : asynchronous serial input, idle high
//   m_axis_tdata    : received word
//   m_axis_tvalid   : word valid
//   m_axis_tready   : sink ready
//   busy            : receiver not in IDLE
//   frame_error     : one-cycle pulse, stop bit sampled low
//   overrun_error   : one-cycle pulse, completed word dropped (register full)
//   parity_error    : (UART_RX_PARITY_EN only) one-cycle pulse, parity mismatch
// -----------------------------------------------------------------------------
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BAUD_DIV    = UART_BAUD_DIV,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_error,
    output logic                  overrun_error
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_error
`endif
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic                  rxd_s;
    uart_state_e           state_q;
    logic [CW-1:0]         cnt_q;
    logic [BW-1:0]         bitcnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  fe_q;
    logic                  oe_q;
    logic                  expire;
    logic                  parity_ok;
    logic                  deliver;
    logic                  load;
    logic                  overrun;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(rxd),
        .sync_o (rxd_s)
    );

    // The count is treated as reaching 0 in the cycle it would step from 1 to
    // 0; acting on it there makes the sample spacing exactly BAUD_DIV clocks.
    assign expire = (cnt_q == CW'(1));

`ifdef UART_RX_PARITY_EN
    logic par_q;
    logic pe_q;
    assign parity_ok = ((^shift_q) == par_q);
`else
    assign parity_ok = 1'b1;
`endif

    // A good stop bit delivers the word; it is accepted when the register is
    // empty or is being emptied by a handshake in this same cycle.
    assign deliver = (state_q == ST_STOP) && expire && rxd_s && parity_ok;
    assign load    = deliver && (!tvalid_q || m_axis_tready);
    assign overrun = deliver && tvalid_q && !m_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            fe_q     <= 1'b0;
            oe_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q    <= 1'b0;
            pe_q     <= 1'b0;
`endif
        end else begin
            fe_q <= 1'b0;
            oe_q <= overrun;
`ifdef UART_RX_PARITY_EN
            pe_q <= 1'b0;
`endif
            if (load) begin
                tdata_q  <= shift_q;
                tvalid_q <= 1'b1;
            end else if (tvalid_q && m_axis_tready) begin
                tvalid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        cnt_q   <= CNT_HALF;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        cnt_q <= CNT_FULL;
                        if (rxd_s) begin
                            state_q <= ST_IDLE;  // glitch, not a start bit
                        end else begin
                            bitcnt_q <= '0;
                            state_q  <= ST_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        // LSB first: each new bit enters at the MSB and the
                        // register shifts right, so bit 0 ends in the LSB.
                        shift_q  <= {rxd_s, shift_q[DATA_WIDTH-1:1]};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        cnt_q    <= CNT_FULL;
                        if (bitcnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (expire) begin
                        par_q   <= rxd_s;
                        cnt_q   <= CNT_FULL;
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (expire) begin
                        cnt_q <= CNT_FULL;
                        if (!rxd_s) begin
                            // Framing error wins over parity; wait for idle.
                            fe_q    <= 1'b1;
                            state_q <= ST_BREAK;
                        end else begin
`ifdef UART_RX_PARITY_EN
                            pe_q    <= !parity_ok;
`endif
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rxd_s) begin
                        cnt_q   <= CNT_FULL;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_error   = fe_q;
    assign overrun_error = oe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_axis.sv
module tb_uart_rx_axis;

    localparam int BD  = 16;
    localparam int DW  = 8;
    localparam int SS  = 2;
    localparam int CYC = 10;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_CYC = (DW + 2 + PBITS) * BD;
    localparam int LAT_NOM   = SS + BD / 2 + (DW + 1 + PBITS) * BD + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxd;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          busy;
    logic          frame_error;
    logic          overrun_error;
`ifdef UART_RX_PARITY_EN
    logic          parity_error;
    bit            par_flip = 1'b0;
    int            pe_cnt = 0;
`endif

    int errors = 0;
    int checks = 0;

    // Passive monitor results (written only by the monitor process).
    logic [DW-1:0] got_mem [0:63];
    int            got_n = 0;
    int            fe_cnt = 0;
    int            oe_cnt = 0;
    int            rise_cnt = 0;
    int            stab_viol = 0;
    time           t_rise = 0;
    logic          prev_vld = 1'b0;
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_data = '0;

    time t_start = 0;
    int  meas_lat = LAT_NOM;

    always #(CYC / 2) clk = ~clk;

    uart_rx_axis #(
        .DATA_WIDTH (DW),
        .BAUD_DIV   (BD),
        .SYNC_STAGES(SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy         (busy),
        .frame_error  (frame_error),
        .overrun_error(overrun_error)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_error (parity_error)
`endif
    );

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready && got_n < 64) begin
            got_mem[got_n] <= m_axis_tdata;
            got_n <= got_n + 1;
        end
        fe_cnt <= fe_cnt + int'(frame_error);
        oe_cnt <= oe_cnt + int'(overrun_error);
`ifdef UART_RX_PARITY_EN
        pe_cnt <= pe_cnt + int'(parity_error);
`endif
        if (m_axis_tvalid && !prev_vld) begin
            t_rise   <= $time;
            rise_cnt <= rise_cnt + 1;
        end
        if (!rst && hold_q && (!m_axis_tvalid || m_axis_tdata !== hold_data))
            stab_viol <= stab_viol + 1;
        hold_q    <= m_axis_tvalid && !m_axis_tready;
        hold_data <= m_axis_tdata;
        prev_vld  <= m_axis_tvalid;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serial frame driver: start, DW data bits LSB first, [parity], stop.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_b);
        t_start = $time;
        rxd = 1'b0;
        wait_cycles(BD);
        for (int i = 0; i < DW; i++) begin
            rxd = d[i];
            wait_cycles(BD);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ par_flip;
        wait_cycles(BD);
`endif
        rxd = stop_b;
        wait_cycles(BD);
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rxd = 1'b1;
        m_axis_tready = 1'b0;
        wait_cycles(4);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 00", m_axis_tdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
        checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun_error); end
        rst = 1'b0;
        wait_cycles(3);
    endtask

    task automatic test_basic;
        int r0, g0, f0, o0, lat;
        r0 = rise_cnt; g0 = got_n; f0 = fe_cnt; o0 = oe_cnt;
        m_axis_tready = 1'b1;
        send_frame(8'h55, 1'b1);
        wait_cycles(BD);
        lat = int'((t_rise - t_start - 4) / CYC);
        meas_lat = lat;
        checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL basic_beats: got %0d want 1", rise_cnt - r0); end
        checks++; if (got_n - g0 != 1 || got_mem[g0] !== 8'h55) begin errors++; $display("FAIL basic_data: got n=%0d d=%h want n=1 d=55", got_n - g0, got_mem[g0]); end
        checks++; if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d+-1", lat, LAT_NOM); end
        checks++; if (fe_cnt != f0 || oe_cnt != o0) begin errors++; $display("FAIL basic_no_errors: got fe=%0d oe=%0d want 0 0", fe_cnt - f0, oe_cnt - o0); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_tvalid_clear: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_glitch;
        int r0, f0;
        r0 = rise_cnt; f0 = fe_cnt;
        rxd = 1'b0;
        wait_cycles(3);
        rxd = 1'b1;
        wait_cycles(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
        wait_cycles(BD);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_drop: got %b want 0", busy); end
        checks++; if (rise_cnt != r0) begin errors++; $display("FAIL glitch_no_tvalid: got %0d want 0", rise_cnt - r0); end
        checks++; if (fe_cnt != f0) begin errors++; $display("FAIL glitch_no_fe: got %0d want 0", fe_cnt - f0); end
    endtask

    task automatic test_frame_error;
        int r0, g0, f0;
        r0 = rise_cnt; g0 = got_n; f0 = fe_cnt;
        m_axis_tready = 1'b1;
        send_frame(8'hA3, 1'b0);
        wait_cycles(BD);
        checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL fe_pulse: got %0d want 1", fe_cnt - f0); end
        checks++; if (rise_cnt != r0) begin errors++; $display("FAIL fe_no_tvalid: got %0d want 0", rise_cnt - r0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_idle: got busy=%b want 0", busy); end
        send_frame(8'h3C, 1'b1);
        wait_cycles(BD);
        checks++; if (got_n - g0 != 1 || got_mem[g0] !== 8'h3C) begin errors++; $display("FAIL fe_next_frame: got n=%0d d=%h want n=1 d=3c", got_n - g0, got_mem[g0]); end
        checks++; if (fe_cnt - f0 != 1) begin errors++; $display("FAIL fe_next_clean: got %0d want 1", fe_cnt - f0); end
        // A line held low for many frame times yields a single framing error.
        rxd = 1'b0;
        wait_cycles(3 * FRAME_CYC);
        rxd = 1'b1;
        wait_cycles(2 * BD);
        checks++; if (fe_cnt - f0 != 2) begin errors++; $display("FAIL break_single_fe: got %0d want 2", fe_cnt - f0); end
        checks++; if (busy !== 1'b0 || got_n - g0 != 1) begin errors++; $display("FAIL break_exit: got busy=%b n=%0d want 0 1", busy, got_n - g0); end
    endtask

    task automatic test_overrun;
        int g0, o0, s0;
        g0 = got_n; o0 = oe_cnt; s0 = stab_viol;
        m_axis_tready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(BD);
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h11) begin errors++; $display("FAIL ovr_hold: got v=%b d=%h want v=1 d=11", m_axis_tvalid, m_axis_tdata); end
        checks++; if (oe_cnt - o0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d want 1", oe_cnt - o0); end
        checks++; if (stab_viol != s0) begin errors++; $display("FAIL ovr_stable: got %0d changes want 0", stab_viol - s0); end
        m_axis_tready = 1'b1;
        wait_cycles(1);
        m_axis_tready = 1'b0;
        wait_cycles(2);
        checks++; if (got_n - g0 != 1 || got_mem[g0] !== 8'h11) begin errors++; $display("FAIL ovr_consume: got n=%0d d=%h want n=1 d=11", got_n - g0, got_mem[g0]); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ovr_tvalid_clear: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_d [0:2];
        int g0, o0, s0;
        exp_d[0] = 8'h01; exp_d[1] = 8'h80; exp_d[2] = 8'hFF;
        g0 = got_n; o0 = oe_cnt; s0 = stab_viol;
        m_axis_tready = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) send_frame(exp_d[k], 1'b1);
            end
            begin
                // Ready for exactly the cycle in which frames 2 and 3 load.
                #(FRAME_CYC * CYC + (meas_lat - 1) * CYC);
                m_axis_tready = 1'b1;
                #(CYC);
                m_axis_tready = 1'b0;
                #(FRAME_CYC * CYC - CYC);
                m_axis_tready = 1'b1;
                #(CYC);
                m_axis_tready = 1'b0;
            end
        join
        wait_cycles(BD);
        m_axis_tready = 1'b1;
        wait_cycles(1);
        m_axis_tready = 1'b0;
        wait_cycles(2);
        checks++; if (got_n - g0 != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got_n - g0); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (got_mem[g0 + k] !== exp_d[k]) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", k, got_mem[g0 + k], exp_d[k]); end
        end
        checks++; if (oe_cnt != o0) begin errors++; $display("FAIL b2b_no_overrun: got %0d want 0", oe_cnt - o0); end
        checks++; if (stab_viol != s0) begin errors++; $display("FAIL b2b_stable: got %0d want 0", stab_viol - s0); end
    endtask

    task automatic test_random;
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] d;
        logic          good;
        int g0, f0, o0, exp_fe;
        g0 = got_n; f0 = fe_cnt; o0 = oe_cnt; exp_fe = 0;
        m_axis_tready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            d    = DW'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(d, good);
            if (good) begin
                exp_q.push_back(d);
                wait_cycles($urandom_range(0, BD));
            end else begin
                exp_fe++;
                wait_cycles(2 * BD);
            end
        end
        wait_cycles(BD);
        checks++; if (got_n - g0 != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", got_n - g0, exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++; if (got_mem[g0 + k] !== exp_q[k]) begin errors++; $display("FAIL rnd_data%0d: got %h want %h", k, got_mem[g0 + k], exp_q[k]); end
        end
        checks++; if (fe_cnt - f0 != exp_fe) begin errors++; $display("FAIL rnd_fe: got %0d want %0d", fe_cnt - f0, exp_fe); end
        checks++; if (oe_cnt != o0) begin errors++; $display("FAIL rnd_overrun: got %0d want 0", oe_cnt - o0); end
    endtask

    task automatic test_reset_mid;
        logic [DW-1:0] d;
        int r0, f0;
        d = 8'h0F;
        m_axis_tready = 1'b0;
        // Leave a word in the output register so clearing tdata is visible.
        send_frame(8'h5A, 1'b1);
        wait_cycles(BD);
        r0 = rise_cnt; f0 = fe_cnt;
        rxd = 1'b0;
        wait_cycles(BD);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            wait_cycles(BD);
        end
        rxd = d[4];
        wait_cycles(BD / 2);
        rst = 1'b1;
        rxd = 1'b1;
        wait_cycles(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy=%b want 0", busy); end
        checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin errors++; $display("FAIL rstmid_outputs: got v=%b d=%h want 0 00", m_axis_tvalid, m_axis_tdata); end
        rst = 1'b0;
        m_axis_tready = 1'b1;
        wait_cycles(FRAME_CYC + BD);
        checks++; if (rise_cnt != r0 || fe_cnt != f0) begin errors++; $display("FAIL rstmid_no_pulse: got beats=%0d fe=%0d want 0 0", rise_cnt - r0, fe_cnt - f0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_stays_idle: got %b want 0", busy); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int r0, g0, p0, f0;
        r0 = rise_cnt; g0 = got_n; p0 = pe_cnt; f0 = fe_cnt;
        m_axis_tready = 1'b1;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        wait_cycles(BD);
        checks++; if (pe_cnt - p0 != 1) begin errors++; $display("FAIL par_pulse: got %0d want 1", pe_cnt - p0); end
        checks++; if (rise_cnt != r0) begin errors++; $display("FAIL par_no_tvalid: got %0d want 0", rise_cnt - r0); end
        // Bad parity and bad stop: only the framing error is reported.
        par_flip = 1'b1;
        send_frame(8'h07, 1'b0);
        par_flip = 1'b0;
        wait_cycles(2 * BD);
        checks++; if (pe_cnt - p0 != 1 || fe_cnt - f0 != 1) begin errors++; $display("FAIL par_fe_precedence: got pe=%0d fe=%0d want 1 1", pe_cnt - p0, fe_cnt - f0); end
        send_frame(8'h07, 1'b1);
        wait_cycles(BD);
        checks++; if (got_n - g0 != 1 || got_mem[g0] !== 8'h07) begin errors++; $display("FAIL par_good: got n=%0d d=%h want n=1 d=07", got_n - g0, got_mem[g0]); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        m_axis_tready = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_glitch;
        test_frame_error;
        test_overrun;
        test_back_to_back;
        test_random;
        test_reset_mid;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
